// File: rtl/boutons_debounce_ctrl.sv
// Avalon-MM push-button controller: two-flop synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, and a masked level interrupt.
module boutons_debounce_ctrl #(
   parameter int unsigned      WIDTH       = 2,
   parameter int unsigned      CNT_W       = 16,
   parameter logic [CNT_W-1:0] LIMIT_RST   = CNT_W'(50000),
   parameter logic [WIDTH-1:0] RESET_LEVEL = '1,
   parameter int unsigned      EDGE_TYPE   = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] AddrData    = 2'd0;
   localparam logic [1:0] AddrLimit   = 2'd1;
   localparam logic [1:0] AddrIrqMask = 2'd2;
   localparam logic [1:0] AddrEdgeCap = 2'd3;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic             wr_en;
   logic [WIDTH-1:0] rise, fall, edge_hit, clr;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   // Debounce: a bit's stable value follows sync once the mismatch has
   // persisted past LIMIT; >= lets a lowered LIMIT take effect at once.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] >= limit_q) begin
               stable_d[i] = sync2_q[i];
            end else if (cnt_q[i] != '1) begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
               cnt_d[i] = cnt_q[i];
            end
         end
      end
   end

   always_comb begin
      rise = stable_d & ~stable_q;
      fall = stable_q & ~stable_d;
      if (EDGE_TYPE == 0) begin
         edge_hit = rise;
      end else if (EDGE_TYPE == 1) begin
         edge_hit = fall;
      end else begin
         edge_hit = rise | fall;
      end
   end

   // Register writes; a new edge overrides a simultaneous clear.
   always_comb begin
      clr     = '0;
      limit_d = limit_q;
      mask_d  = mask_q;
      if (wr_en) begin
         case (address)
            AddrLimit:   limit_d = writedata[CNT_W-1:0];
            AddrIrqMask: mask_d  = writedata[WIDTH-1:0];
            AddrEdgeCap: clr     = writedata[WIDTH-1:0];
            default:     ;
         endcase
      end
      edgecap_d = (edgecap_q & ~clr) | edge_hit;
      irq_d     = |(edgecap_q & mask_q);
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         AddrData:    readdata_d = 32'(stable_q);
         AddrLimit:   readdata_d = 32'(limit_q);
         AddrIrqMask: readdata_d = 32'(mask_q);
         AddrEdgeCap: readdata_d = 32'(edgecap_q);
         default:     readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= RESET_LEVEL;
         sync2_q    <= RESET_LEVEL;
         stable_q   <= RESET_LEVEL;
         edgecap_q  <= '0;
         mask_q     <= '0;
         limit_q    <= LIMIT_RST;
         readdata_q <= '0;
         irq_q      <= 1'b0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         edgecap_q  <= edgecap_d;
         mask_q     <= mask_d;
         limit_q    <= limit_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_boutons_debounce_ctrl.sv
// Bench for boutons_debounce_ctrl: directed plan steps plus random pin/register
// traffic, checked by a queue-based scoreboard against a run-length model.
module tb_boutons_debounce_ctrl;

   localparam int W = 2;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic [1:0]    address    = 2'd0;
   logic          chipselect = 1'b0;
   logic          write_n    = 1'b1;
   logic [31:0]   writedata  = 32'd0;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port    = 2'b11;
   logic          irq;

   always #5 clk = ~clk;

   boutons_debounce_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stable adopts the synchronised pin value once the two have
   // disagreed for more than LIMIT consecutive cycles; falling edges are captured.
   logic [W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask;
   int           m_run [W];
   int           m_limit;
   logic         m_irq, m_pend;
   logic [31:0]  exp_q [$];

   logic [W-1:0] nx_stable, nx_cap, nx_clr;
   int           nx_run [W];
   logic [31:0]  nx_rd;
   logic         m_wr;

   always_comb begin
      m_wr      = chipselect && !write_n;
      nx_stable = m_stable;
      for (int i = 0; i < W; i++) begin
         nx_run[i] = 0;
         if (m_s2[i] != m_stable[i]) begin
            if (m_run[i] + 1 > m_limit) nx_stable[i] = m_s2[i];
            else nx_run[i] = m_run[i] + 1;
         end
      end
      nx_clr = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
      nx_cap = (m_cap & ~nx_clr) | (m_stable & ~nx_stable);
      case (address)
         2'd0:    nx_rd = {30'd0, m_stable};
         2'd1:    nx_rd = 32'(m_limit);
         2'd2:    nx_rd = {30'd0, m_mask};
         default: nx_rd = {30'd0, m_cap};
      endcase
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1     <= 2'b11;
         m_s2     <= 2'b11;
         m_stable <= 2'b11;
         m_cap    <= '0;
         m_mask   <= '0;
         m_limit  <= 50000;
         m_irq    <= 1'b0;
         m_pend   <= 1'b0;
         for (int i = 0; i < W; i++) m_run[i] <= 0;
         exp_q.delete();
      end else begin
         m_s1     <= in_port;
         m_s2     <= m_s1;
         m_stable <= nx_stable;
         m_cap    <= nx_cap;
         m_irq    <= |(m_cap & m_mask);
         for (int i = 0; i < W; i++) m_run[i] <= nx_run[i];
         if (m_wr && address == 2'd1) m_limit <= int'(writedata[15:0]);
         if (m_wr && address == 2'd2) m_mask <= writedata[W-1:0];
         exp_q.push_back(nx_rd);
         m_pend <= 1'b1;
      end
   end

   // Monitor: readdata presents a new registered value after every active edge.
   always @(negedge clk) begin
      if (reset_n && m_pend) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            check("readdata", readdata, exp_q.pop_front());
         end
         check("irq", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic peek(input string name, input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a;
      @(negedge clk);
      check(name, readdata, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      idle(3);
      reset_n = 1'b1;

      // 1: reset values
      peek("rst_data", 2'd0, 32'h3);
      peek("rst_limit", 2'd1, 32'd50000);
      peek("rst_mask", 2'd2, 32'h0);
      peek("rst_edgecap", 2'd3, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'd0);

      // 2: held low level, LIMIT=3
      wr_reg(2'd1, 32'd3);
      wr_reg(2'd2, 32'd1);
      @(negedge clk);
      address    = 2'd0;
      in_port[0] = 1'b0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (readdata[0] == 1'b0) break;
      end
      check("latency_limit3", 32'(n - 1), 32'd6);
      check("irq_after_cap", {31'd0, irq}, 32'd1);
      peek("edgecap_bit0", 2'd3, 32'h1);

      // 3: short glitch is rejected
      in_port = 2'b11;
      idle(10);
      wr_reg(2'd3, 32'h3);
      @(negedge clk);
      in_port[0] = 1'b0;
      idle(3);
      in_port[0] = 1'b1;
      idle(10);
      peek("glitch_data", 2'd0, 32'h3);
      peek("glitch_edgecap", 2'd3, 32'h0);

      // 4: write-1-to-clear and set-wins collision
      in_port = 2'b00;
      idle(8);
      peek("both_captured", 2'd3, 32'h3);
      wr_reg(2'd3, 32'h1);
      peek("clear_bit0", 2'd3, 32'h2);
      idle(2);
      check("irq_masked", {31'd0, irq}, 32'd0);
      in_port = 2'b11;
      idle(8);
      @(negedge clk);
      in_port[0] = 1'b0;
      idle(4);
      wr_reg(2'd3, 32'h1);
      peek("set_wins", 2'd3, 32'h3);

      // 5: lowering LIMIT mid-count
      in_port = 2'b11;
      idle(8);
      wr_reg(2'd3, 32'h3);
      wr_reg(2'd1, 32'd10);
      @(negedge clk);
      in_port[0] = 1'b0;
      idle(8);
      wr_reg(2'd1, 32'd2);
      peek("limit_lowered", 2'd0, 32'h2);

      // 6: reset mid-count
      in_port = 2'b11;
      idle(8);
      wr_reg(2'd1, 32'd3);
      wr_reg(2'd3, 32'h3);
      wr_reg(2'd2, 32'h3);
      in_port = 2'b01;
      idle(8);
      in_port = 2'b00;
      idle(4);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_readdata", readdata, 32'd0);
      check("mid_rst_irq", {31'd0, irq}, 32'd0);
      idle(3);
      @(posedge clk);
      #2 reset_n = 1'b1;
      wr_reg(2'd1, 32'd3);
      address = 2'd0;
      for (n = 2; n <= 30; n++) begin
         @(negedge clk);
         if (readdata[1:0] == 2'b00) break;
      end
      check("post_rst_latency", 32'(n - 1), 32'd6);
      peek("post_rst_edgecap", 2'd3, 32'h3);

      // random traffic
      wr_reg(2'd1, 32'($urandom_range(0, 4)));
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 5))
            0: in_port = W'($urandom);
            1: wr_reg(2'd3, $urandom);
            2: wr_reg(2'd2, $urandom);
            3: wr_reg(2'd1, 32'($urandom_range(0, 5)) | ($urandom & 32'hFFFF_0000));
            4: wr_reg(2'd0, $urandom);
            default: begin
               @(negedge clk);
               address   = 2'($urandom);
               writedata = $urandom;
            end
         endcase
         idle($urandom_range(0, 6));
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
